// File: rtl/cache_pkg.sv
// Shared widths and address decoding for one cache line of a 4-way set-associative data cache.
package cache_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned OFFSET_W    = 4;
  localparam int unsigned INDEX_W     = 6;
  localparam int unsigned TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned BLOCK_BYTES = 1 << OFFSET_W;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned AGE_W       = 2;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(3);

  // Fields of a byte address as seen by one line.
  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  // Split a byte address into tag, set index and byte offset.
  function automatic addr_fields_t split_address(input logic [ADDR_W-1:0] addr);
    addr_fields_t f;
    f.tag    = addr[ADDR_W-1 -: TAG_W];
    f.index  = addr[OFFSET_W +: INDEX_W];
    f.offset = addr[OFFSET_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/cache_age_counter.sv
// 2-bit saturating LRU age counter; clear wins over increment, all updates gated by en.
module cache_age_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  output logic [AGE_W-1:0] age
);

  logic [AGE_W-1:0] r_age;

  // Age register: clear has priority, increment saturates at AGE_MAX.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_age <= '0;
    end else if (en) begin
      if (clr) begin
        r_age <= '0;
      end else if (inc && (r_age != AGE_MAX)) begin
        r_age <= r_age + AGE_W'(1);
      end
    end
  end

  assign age = r_age;

endmodule

// File: rtl/cache_line.sv
// One way of one set: tag/valid/block storage, tag compare, byte read/write, LRU age.
// Optional dirty tracking is enabled by defining CACHE_LINE_DIRTY_EN.
module cache_line
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              ready,
  input  logic [ADDR_W-1:0] address_word,
  input  logic              try_read,
  input  logic              try_write,
  input  logic [BYTE_W-1:0] write_data,
  input  logic              reset_age,
  input  logic              increment_age,
  output logic [BYTE_W-1:0] data,
  output logic [AGE_W-1:0]  age,
  output logic              hit_miss,
  output logic              is_empty
`ifdef CACHE_LINE_DIRTY_EN
  ,
  output logic              dirty
`endif
);

  logic                               r_valid;
  logic [TAG_W-1:0]                   r_tag;
  logic [BLOCK_BYTES-1:0][BYTE_W-1:0] r_block;
  logic [BYTE_W-1:0]                  r_data;

  addr_fields_t         w_fields;
  logic                 w_hit;
  logic                 w_do_write;
  logic                 w_do_read;
  logic [INDEX_W-1:0]   w_unused_index;

  // Address decode and tag compare; independent of ready and the access strobes.
  always_comb begin
    w_fields       = split_address(address_word);
    w_unused_index = w_fields.index;
    w_hit          = r_valid && (r_tag == w_fields.tag);
    w_do_write     = ready && try_write;
    w_do_read      = ready && try_read && !try_write;
  end

  // Tag, valid and block storage: write hit updates one byte, write miss allocates a zeroed block.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_block <= '0;
    end else if (w_do_write) begin
      if (w_hit) begin
        r_block[w_fields.offset] <= write_data;
      end else begin
        r_valid                  <= 1'b1;
        r_tag                    <= w_fields.tag;
        r_block                  <= '0;
        r_block[w_fields.offset] <= write_data;
      end
    end
  end

  // Registered read data: loaded only on a read hit, otherwise holds.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_data <= '0;
    end else if (w_do_read && w_hit) begin
      r_data <= r_block[w_fields.offset];
    end
  end

`ifdef CACHE_LINE_DIRTY_EN
  logic r_dirty;

  // Dirty flag: set by any write (hit or allocate), cleared only by reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_dirty <= 1'b0;
    end else if (w_do_write) begin
      r_dirty <= 1'b1;
    end
  end

  assign dirty = r_dirty;
`endif

  cache_age_counter u_age (
    .clk   (clk),
    .rst_b (rst_b),
    .en    (ready),
    .clr   (reset_age),
    .inc   (increment_age),
    .age   (age)
  );

  assign data     = r_data;
  assign hit_miss = w_hit;
  assign is_empty = !r_valid;

endmodule

// File: tb/tb_cache_line.sv
// Scoreboard bench for cache_line: driver updates a behavioural line model and queues
// expectations; a monitor pops them and compares against the DUT.
module tb_cache_line;

  logic        clk;
  logic        rst_b;
  logic        ready;
  logic [31:0] address_word;
  logic        try_read;
  logic        try_write;
  logic [7:0]  write_data;
  logic        reset_age;
  logic        increment_age;
  logic [7:0]  data;
  logic [1:0]  age;
  logic        hit_miss;
  logic        is_empty;
`ifdef CACHE_LINE_DIRTY_EN
  logic        dirty;
`endif

  cache_line dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .ready         (ready),
    .address_word  (address_word),
    .try_read      (try_read),
    .try_write     (try_write),
    .write_data    (write_data),
    .reset_age     (reset_age),
    .increment_age (increment_age),
    .data          (data),
    .age           (age),
    .hit_miss      (hit_miss),
    .is_empty      (is_empty)
`ifdef CACHE_LINE_DIRTY_EN
    ,
    .dirty         (dirty)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       hit;
    logic       empty;
    logic [7:0] data;
    logic [1:0] age;
    logic       dirty;
  } exp_t;

  exp_t q[$];
  bit   mon_busy;
  int   n_cmp;
  int   n_err;

  // Behavioural line model.
  byte unsigned m_mem[16];
  bit           m_valid;
  int unsigned  m_tag;
  byte unsigned m_data;
  int           m_age;
  bit           m_dirty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    m_valid = 1'b0;
    m_tag   = 0;
    m_data  = 8'h00;
    m_age   = 0;
    m_dirty = 1'b0;
  endtask

  // Apply one cycle of stimulus mid-cycle, advance the model, queue expectations.
  task automatic drive(input bit rdy, input logic [31:0] a, input bit rd, input bit wr,
                       input logic [7:0] wd, input bit ra, input bit ia);
    exp_t        e;
    int unsigned tag;
    int unsigned off;
    bit          hit;
    @(posedge clk);
    #2;
    ready         = rdy;
    address_word  = a;
    try_read      = rd;
    try_write     = wr;
    write_data    = wd;
    reset_age     = ra;
    increment_age = ia;
    tag = a >> 10;
    off = a % 16;
    hit = m_valid && (m_tag == tag);
    e.hit   = hit;
    e.empty = !m_valid;
    if (rdy) begin
      if (wr) begin
        if (!hit) begin
          foreach (m_mem[i]) m_mem[i] = 8'h00;
          m_tag   = tag;
          m_valid = 1'b1;
        end
        m_mem[off] = wd;
        m_dirty    = 1'b1;
      end else if (rd && hit) begin
        m_data = m_mem[off];
      end
      if (ra) m_age = 0;
      else if (ia) m_age = (m_age >= 3) ? 3 : m_age + 1;
    end
    e.data  = m_data;
    e.age   = 2'(m_age);
    e.dirty = m_dirty;
    q.push_back(e);
  endtask

  // Wait for the monitor to consume everything queued, with a cycle budget.
  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || mon_busy) && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0 || mon_busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    mon_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        mon_busy = 1'b1;
        e = q.pop_front();
        chk("hit_miss", 32'(hit_miss), 32'(e.hit));
        chk("is_empty", 32'(is_empty), 32'(e.empty));
        @(posedge clk);
        #1;
        chk("data", 32'(data), 32'(e.data));
        chk("age", 32'(age), 32'(e.age));
`ifdef CACHE_LINE_DIRTY_EN
        chk("dirty", 32'(dirty), 32'(e.dirty));
`endif
        mon_busy = 1'b0;
      end
    end
  end

  logic [31:0] bases[3];

  initial begin
    logic [31:0] a;
    n_cmp = 0;
    n_err = 0;
    bases[0] = 32'h1234_5678;
    bases[1] = 32'h8765_4328;
    bases[2] = 32'hDEAD_B000;
    ready = 1'b0; address_word = '0; try_read = 1'b0; try_write = 1'b0;
    write_data = '0; reset_age = 1'b0; increment_age = 1'b0;
    model_reset();
    rst_b = 1'b1;
    #1 rst_b = 1'b0;
    #10;
    chk("rst_is_empty", 32'(is_empty), 32'd1);
    chk("rst_hit_miss", 32'(hit_miss), 32'd0);
    chk("rst_age", 32'(age), 32'd0);
    chk("rst_data", 32'(data), 32'h00);
    #1 rst_b = 1'b1;

    // Write-allocate, read back, read a neighbouring byte.
    drive(1, 32'h1234_5678, 0, 1, 8'hA5, 0, 0);
    drive(1, 32'h1234_5678, 1, 0, 8'h00, 0, 0);
    drive(1, 32'h1234_5670, 1, 0, 8'h00, 0, 0);
    drive(1, 32'h1234_5678, 1, 0, 8'h00, 0, 0);
    // Read miss holds data; write miss replaces tag; old address now misses.
    drive(1, 32'h8765_4328, 1, 0, 8'h00, 0, 0);
    drive(1, 32'h8765_4328, 0, 1, 8'h3C, 0, 0);
    drive(1, 32'h1234_5678, 1, 0, 8'h00, 0, 0);
    drive(1, 32'h8765_4328, 1, 0, 8'h00, 0, 0);
    // Age saturation and clear priority.
    for (int i = 0; i < 5; i++) drive(1, 32'h8765_4328, 0, 0, 8'h00, 0, 1);
    drive(1, 32'h8765_4328, 0, 0, 8'h00, 1, 1);
    // ready low freezes everything.
    for (int i = 0; i < 3; i++) drive(0, 32'h1111_1111, 0, 1, 8'hEE, 0, 1);
    // Read and write together on a hit: write wins, data unchanged; then read it back.
    drive(1, 32'h8765_4328, 1, 1, 8'h77, 0, 0);
    drive(1, 32'h8765_4328, 1, 0, 8'h00, 0, 0);

    // Randomized traffic over a small tag pool so hits are frequent.
    for (int i = 0; i < 400; i++) begin
      a = (bases[$urandom_range(0, 2)] & 32'hFFFF_FC00) | ($urandom & 32'h3FF);
      drive(($urandom_range(0, 9) != 0), a, 1'($urandom), 1'($urandom_range(0, 3) == 0),
            8'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    drain();

    // Asynchronous reset in the middle of a write cycle.
    drive(1, 32'h1234_5678, 0, 1, 8'h5A, 0, 1);
    drain();
    @(posedge clk);
    #2;
    ready = 1'b1; address_word = 32'h1234_5678; try_write = 1'b1; try_read = 1'b0;
    write_data = 8'h99; increment_age = 1'b1; reset_age = 1'b0;
    #3 rst_b = 1'b0;
    #1;
    chk("arst_is_empty", 32'(is_empty), 32'd1);
    chk("arst_hit_miss", 32'(hit_miss), 32'd0);
    chk("arst_age", 32'(age), 32'd0);
    chk("arst_data", 32'(data), 32'h00);
`ifdef CACHE_LINE_DIRTY_EN
    chk("arst_dirty", 32'(dirty), 32'd0);
`endif
    model_reset();
    try_write = 1'b0; increment_age = 1'b0;
    #2 rst_b = 1'b1;
    drive(1, 32'h1234_5678, 1, 0, 8'h00, 0, 0);
    drive(1, 32'h1234_5678, 0, 1, 8'h42, 0, 0);
    drive(1, 32'h1234_5678, 1, 0, 8'h00, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
